br_issue_sched: RTL and testbench
=================================

BR_ISSUE_SCHED -- requirements
Module: br_issue_sched

Interface
REQ-001 SHALL have parameter BR_IQ_DEPTH, default 4: number of branch issue-queue entries (power of two, at least 2).
REQ-002 SHALL have ports clk (in, 1: clock) and rst (in, 1: reset); one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port flush (in, 1): mispredict/exception flush; clears the queue.
REQ-004 SHALL have dispatch ports in: disp_valid 1, disp_op `DATA_WIDTH_BR_OP, disp_pc `PC_WIDTH, disp_imm `WORD_WIDTH, disp_Pdst $clog2(`ROB_DEPTH).
REQ-005 SHALL have per-source dispatch ports in, for i = 1, 2: disp_rsi_rdy 1, disp_rsi_tag $clog2(`ROB_DEPTH), disp_rsi_value `WORD_WIDTH.
REQ-006 SHALL have port disp_ready (out, 1): queue can accept an entry this cycle.
REQ-007 SHALL have wakeup ports in: cdb_valid 1, cdb_rob $clog2(`ROB_DEPTH), cdb_value `WORD_WIDTH.
REQ-008 SHALL have issue ports out, driving the branch unit: br_issue_en 1, br_issue_queue_op, br_issue_queue_pc, br_issue_queue_imm, br_issue_queue_rs1_value, br_issue_queue_rs2_value, br_issue_queue_Pdst_out (widths as REQ-004/005).
REQ-009 SHALL have port iq_count (out, $clog2(BR_IQ_DEPTH)+1): occupied entries.

Function
REQ-010 SHALL hold entries in a collapsing age-ordered array: slot 0 is the oldest, valid slots are contiguous from slot 0.
REQ-011 SHALL drive disp_ready = (iq_count < BR_IQ_DEPTH), using the registered count only; an issue in the same cycle does not raise it.
REQ-012 SHALL write a new entry at the clock edge when disp_valid && disp_ready && !flush, into slot iq_count less the number of entries issued that cycle.
REQ-013 SHALL, on enqueue, mark a source ready and take cdb_value when cdb_valid is high and cdb_rob equals a not-ready disp_rsi_tag (same-cycle capture).
REQ-014 SHALL, each cycle, set a valid entry's not-ready source ready and latch cdb_value when cdb_valid is high and the tags match; both sources may wake in the same cycle.
REQ-015 SHALL select the lowest-index valid entry with both sources ready, using registered state only: no CDB-to-select bypass.
REQ-016 SHALL, at the edge following a selection, copy the selected entry to the registered issue outputs, set br_issue_en = 1 for one cycle, and shift the younger entries down by one.
REQ-017 SHALL set br_issue_en = 0 when no entry is ready; issue data outputs then hold their last value.
REQ-018 SHALL issue at most one entry per cycle; the branch unit has no backpressure.
REQ-019 SHALL give latency: dispatch with both sources ready at edge N -> br_issue_en high in cycle N+2; wakeup by CDB in cycle k -> earliest br_issue_en in cycle k+2.
REQ-020 SHALL, when flush = 1 at an edge, clear all valid bits, set iq_count = 0 and br_issue_en = 0; flush takes priority over enqueue, wakeup and issue.
REQ-021 SHALL, on simultaneous issue and enqueue, give the new entry the slot just past the shifted entries, so iq_count is unchanged.
REQ-022 SHALL ignore CDB broadcasts that match no waiting tag, and SHALL NOT change any already-ready source.

Reset
REQ-023 SHALL, on rst, asynchronously clear all valid bits and set iq_count = 0 and br_issue_en = 0; all issue data outputs and entry payloads reset to 0.
REQ-024 SHALL drive disp_ready = 1 during and after reset; reset in mid-operation discards all entries with no partial issue.

Structure
REQ-025 SHALL take `DATA_WIDTH_BR_OP, `BR_OP_* encodings, `WORD_WIDTH, `PC_WIDTH and `ROB_DEPTH from the shared define header; BR_IQ_DEPTH stays a local parameter.
REQ-026 SHALL contain one sub-module, br_iq_select: a combinational oldest-ready priority picker returning grant valid and index.
REQ-027 SHALL connect its issue outputs port-for-port to the branch functional unit, with no glue logic.

Verification
REQ-028 SHALL cover: after reset, dispatch BEQ pc=0x100, imm=0x20, both sources ready (rs1 = rs2 = 5) at edge N -> br_issue_en high in cycle N+2, pc=0x100, imm=0x20, values 5/5.
REQ-029 SHALL cover: dispatch A (rs1 waits on tag 3), then B (ready); CDB rob=3, value=7 in cycle k -> B issues first, A issues in cycle k+2 with rs1_value=7.
REQ-030 SHALL cover: fill 4 entries, none ready -> disp_ready=0, iq_count=4; a 5th disp_valid is dropped; wake slot 2 -> it issues, the others shift, and disp_ready returns 1 one cycle later.
REQ-031 SHALL cover: dispatch with rs2_tag=9 while cdb_valid with rob=9, value=0xDEAD in the same cycle -> the entry issues with rs2_value=0xDEAD and no further wakeup.
REQ-032 SHALL cover: 3 entries, one ready; flush and disp_valid in the same cycle -> next cycle iq_count=0, br_issue_en=0, and nothing issues afterwards.
REQ-033 SHALL cover: assert rst while 2 entries are ready -> outputs are zero immediately; after release, no stale issue occurs.

Source files
------------

// File: rtl/br_issue_sched_pkg.sv
// Shared branch-pipeline widths and encodings, plus the entry layout and
// the CDB wakeup helper used by the branch issue queue.
`ifndef BR_ISSUE_SCHED_DEFS
`define BR_ISSUE_SCHED_DEFS
`define DATA_WIDTH_BR_OP 3
`define BR_OP_BEQ  3'd0
`define BR_OP_BNE  3'd1
`define BR_OP_BLT  3'd2
`define BR_OP_BGE  3'd3
`define BR_OP_BLTU 3'd4
`define BR_OP_BGEU 3'd5
`define BR_OP_JAL  3'd6
`define BR_OP_JALR 3'd7
`define WORD_WIDTH 32
`define PC_WIDTH   32
`define ROB_DEPTH  16
`endif

package br_issue_sched_pkg;

    localparam int unsigned OP_W   = `DATA_WIDTH_BR_OP;
    localparam int unsigned WORD_W = `WORD_WIDTH;
    localparam int unsigned PC_W   = `PC_WIDTH;
    localparam int unsigned ROB_D  = `ROB_DEPTH;
    localparam int unsigned TAG_W  = $clog2(`ROB_DEPTH);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] value;
    } br_src_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [PC_W-1:0]   pc;
        logic [WORD_W-1:0] imm;
        logic [TAG_W-1:0]  pdst;
        br_src_t           rs1;
        br_src_t           rs2;
    } br_iq_entry_t;

    // A waiting source captures the broadcast value on a tag match; ready sources never change.
    function automatic br_src_t src_wakeup(
        input br_src_t           src,
        input logic              cdb_valid,
        input logic [TAG_W-1:0]  cdb_rob,
        input logic [WORD_W-1:0] cdb_value
    );
        br_src_t res;
        res = src;
        if (!src.rdy && cdb_valid && (src.tag == cdb_rob)) begin
            res.rdy   = 1'b1;
            res.value = cdb_value;
        end
        return res;
    endfunction

endpackage

// File: rtl/br_iq_select.sv
// Oldest-ready picker: grants the lowest-index asserted request.
module br_iq_select #(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req_i,
    output logic                     gnt_valid_o,
    output logic [$clog2(DEPTH)-1:0] gnt_idx_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic                 found;
    logic [IDX_W-1:0]     idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (req_i[i] && !found) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

    assign gnt_valid_o = found;
    assign gnt_idx_o   = idx;

endmodule

// File: rtl/br_issue_sched.sv
// Branch issue queue: collapsing age-ordered entries, CDB wakeup, and
// oldest-ready single issue into registered branch-unit outputs.
module br_issue_sched
    import br_issue_sched_pkg::*;
#(
    parameter int unsigned BR_IQ_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,

    input  logic                             disp_valid,
    input  logic [`DATA_WIDTH_BR_OP-1:0]     disp_op,
    input  logic [`PC_WIDTH-1:0]             disp_pc,
    input  logic [`WORD_WIDTH-1:0]           disp_imm,
    input  logic [$clog2(`ROB_DEPTH)-1:0]    disp_Pdst,
    input  logic                             disp_rs1_rdy,
    input  logic [$clog2(`ROB_DEPTH)-1:0]    disp_rs1_tag,
    input  logic [`WORD_WIDTH-1:0]           disp_rs1_value,
    input  logic                             disp_rs2_rdy,
    input  logic [$clog2(`ROB_DEPTH)-1:0]    disp_rs2_tag,
    input  logic [`WORD_WIDTH-1:0]           disp_rs2_value,
    output logic                             disp_ready,

    input  logic                             cdb_valid,
    input  logic [$clog2(`ROB_DEPTH)-1:0]    cdb_rob,
    input  logic [`WORD_WIDTH-1:0]           cdb_value,

    output logic                             br_issue_en,
    output logic [`DATA_WIDTH_BR_OP-1:0]     br_issue_queue_op,
    output logic [`PC_WIDTH-1:0]             br_issue_queue_pc,
    output logic [`WORD_WIDTH-1:0]           br_issue_queue_imm,
    output logic [`WORD_WIDTH-1:0]           br_issue_queue_rs1_value,
    output logic [`WORD_WIDTH-1:0]           br_issue_queue_rs2_value,
    output logic [$clog2(`ROB_DEPTH)-1:0]    br_issue_queue_Pdst_out,

    output logic [$clog2(BR_IQ_DEPTH):0]     iq_count
);

    localparam int unsigned IDX_W = $clog2(BR_IQ_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BR_IQ_DEPTH);

    br_iq_entry_t            entries_q [BR_IQ_DEPTH];
    br_iq_entry_t            entries_d [BR_IQ_DEPTH];
    br_iq_entry_t            ent_wk    [BR_IQ_DEPTH];
    br_iq_entry_t            new_ent;
    br_src_t                 rs1_in;
    br_src_t                 rs2_in;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [CNT_W-1:0]        enq_slot;
    logic                    enq;
    logic [BR_IQ_DEPTH-1:0]  req;
    logic                    gnt_valid;
    logic [IDX_W-1:0]        gnt_idx;

    logic                    iss_en_q;
    logic [OP_W-1:0]         iss_op_q;
    logic [PC_W-1:0]         iss_pc_q;
    logic [WORD_W-1:0]       iss_imm_q;
    logic [WORD_W-1:0]       iss_rs1_q;
    logic [WORD_W-1:0]       iss_rs2_q;
    logic [TAG_W-1:0]        iss_pdst_q;

    assign disp_ready = (count_q < DEPTH_CNT);
    assign enq        = disp_valid && disp_ready && !flush;

    // Selection looks only at registered readiness, so a CDB hit issues no earlier than two cycles later.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
            req[i] = entries_q[i].valid && entries_q[i].rs1.rdy && entries_q[i].rs2.rdy;
        end
    end

    br_iq_select #(
        .DEPTH(BR_IQ_DEPTH)
    ) u_select (
        .req_i      (req),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );

    always_comb begin
        rs1_in = {disp_rs1_rdy, disp_rs1_tag, disp_rs1_value};
        rs2_in = {disp_rs2_rdy, disp_rs2_tag, disp_rs2_value};

        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.op    = disp_op;
        new_ent.pc    = disp_pc;
        new_ent.imm   = disp_imm;
        new_ent.pdst  = disp_Pdst;
        new_ent.rs1   = src_wakeup(rs1_in, cdb_valid, cdb_rob, cdb_value);
        new_ent.rs2   = src_wakeup(rs2_in, cdb_valid, cdb_rob, cdb_value);

        for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
            ent_wk[i] = entries_q[i];
            if (entries_q[i].valid) begin
                ent_wk[i].rs1 = src_wakeup(entries_q[i].rs1, cdb_valid, cdb_rob, cdb_value);
                ent_wk[i].rs2 = src_wakeup(entries_q[i].rs2, cdb_valid, cdb_rob, cdb_value);
            end
        end

        // Collapse: everything at or above the issued slot moves down one.
        for (int unsigned i = 0; i < BR_IQ_DEPTH - 1; i++) begin
            if (gnt_valid && (IDX_W'(i) >= gnt_idx)) begin
                entries_d[i] = ent_wk[i + 1];
            end else begin
                entries_d[i] = ent_wk[i];
            end
        end
        if (gnt_valid) begin
            entries_d[BR_IQ_DEPTH-1] = '0;
        end else begin
            entries_d[BR_IQ_DEPTH-1] = ent_wk[BR_IQ_DEPTH-1];
        end

        enq_slot = count_q - CNT_W'(gnt_valid);
        if (enq) begin
            for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
                if (CNT_W'(i) == enq_slot) begin
                    entries_d[i] = new_ent;
                end
            end
        end

        count_d = count_q - CNT_W'(gnt_valid) + CNT_W'(enq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q    <= '0;
            iss_en_q   <= 1'b0;
            iss_op_q   <= '0;
            iss_pc_q   <= '0;
            iss_imm_q  <= '0;
            iss_rs1_q  <= '0;
            iss_rs2_q  <= '0;
            iss_pdst_q <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < BR_IQ_DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
            count_q  <= '0;
            iss_en_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            iss_en_q  <= gnt_valid;
            if (gnt_valid) begin
                iss_op_q   <= entries_q[gnt_idx].op;
                iss_pc_q   <= entries_q[gnt_idx].pc;
                iss_imm_q  <= entries_q[gnt_idx].imm;
                iss_rs1_q  <= entries_q[gnt_idx].rs1.value;
                iss_rs2_q  <= entries_q[gnt_idx].rs2.value;
                iss_pdst_q <= entries_q[gnt_idx].pdst;
            end
        end
    end

    assign br_issue_en              = iss_en_q;
    assign br_issue_queue_op        = iss_op_q;
    assign br_issue_queue_pc        = iss_pc_q;
    assign br_issue_queue_imm       = iss_imm_q;
    assign br_issue_queue_rs1_value = iss_rs1_q;
    assign br_issue_queue_rs2_value = iss_rs2_q;
    assign br_issue_queue_Pdst_out  = iss_pdst_q;
    assign iq_count                 = count_q;

endmodule

// File: tb/tb_br_issue_sched.sv
// Directed bench for br_issue_sched: issued entries are matched in order
// against a scoreboard queue filled when the stimulus is driven.
module tb_br_issue_sched;
    import br_issue_sched_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              disp_valid;
    logic [OP_W-1:0]   disp_op;
    logic [PC_W-1:0]   disp_pc;
    logic [WORD_W-1:0] disp_imm;
    logic [TAG_W-1:0]  disp_Pdst;
    logic              disp_rs1_rdy;
    logic [TAG_W-1:0]  disp_rs1_tag;
    logic [WORD_W-1:0] disp_rs1_value;
    logic              disp_rs2_rdy;
    logic [TAG_W-1:0]  disp_rs2_tag;
    logic [WORD_W-1:0] disp_rs2_value;
    logic              disp_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_rob;
    logic [WORD_W-1:0] cdb_value;
    logic              br_issue_en;
    logic [OP_W-1:0]   br_issue_queue_op;
    logic [PC_W-1:0]   br_issue_queue_pc;
    logic [WORD_W-1:0] br_issue_queue_imm;
    logic [WORD_W-1:0] br_issue_queue_rs1_value;
    logic [WORD_W-1:0] br_issue_queue_rs2_value;
    logic [TAG_W-1:0]  br_issue_queue_Pdst_out;
    logic [$clog2(DEPTH):0] iq_count;

    br_issue_sched #(
        .BR_IQ_DEPTH(DEPTH)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .flush                   (flush),
        .disp_valid              (disp_valid),
        .disp_op                 (disp_op),
        .disp_pc                 (disp_pc),
        .disp_imm                (disp_imm),
        .disp_Pdst               (disp_Pdst),
        .disp_rs1_rdy            (disp_rs1_rdy),
        .disp_rs1_tag            (disp_rs1_tag),
        .disp_rs1_value          (disp_rs1_value),
        .disp_rs2_rdy            (disp_rs2_rdy),
        .disp_rs2_tag            (disp_rs2_tag),
        .disp_rs2_value          (disp_rs2_value),
        .disp_ready              (disp_ready),
        .cdb_valid               (cdb_valid),
        .cdb_rob                 (cdb_rob),
        .cdb_value               (cdb_value),
        .br_issue_en             (br_issue_en),
        .br_issue_queue_op       (br_issue_queue_op),
        .br_issue_queue_pc       (br_issue_queue_pc),
        .br_issue_queue_imm      (br_issue_queue_imm),
        .br_issue_queue_rs1_value(br_issue_queue_rs1_value),
        .br_issue_queue_rs2_value(br_issue_queue_rs2_value),
        .br_issue_queue_Pdst_out (br_issue_queue_Pdst_out),
        .iq_count                (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [PC_W-1:0]   pc;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] v1;
        logic [WORD_W-1:0] v2;
        logic [TAG_W-1:0]  pdst;
    } exp_t;

    exp_t        sb[$];
    exp_t        want;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [PC_W-1:0] pc,
                            input logic [WORD_W-1:0] imm, input logic [TAG_W-1:0] pdst,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [WORD_W-1:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [WORD_W-1:0] v2);
        disp_valid     = 1'b1;
        disp_op        = op;
        disp_pc        = pc;
        disp_imm       = imm;
        disp_Pdst      = pdst;
        disp_rs1_rdy   = r1;
        disp_rs1_tag   = t1;
        disp_rs1_value = v1;
        disp_rs2_rdy   = r2;
        disp_rs2_tag   = t2;
        disp_rs2_value = v2;
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [PC_W-1:0] pc,
                        input logic [WORD_W-1:0] imm, input logic [WORD_W-1:0] v1,
                        input logic [WORD_W-1:0] v2, input logic [TAG_W-1:0] pdst);
        exp_t e;
        e.op = op; e.pc = pc; e.imm = imm; e.v1 = v1; e.v2 = v2; e.pdst = pdst;
        sb.push_back(e);
    endtask

    task automatic cdb(input logic v, input logic [TAG_W-1:0] rob, input logic [WORD_W-1:0] val);
        cdb_valid = v;
        cdb_rob   = rob;
        cdb_value = val;
    endtask

    // Every issue pulse is checked against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && br_issue_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", 64'(br_issue_en), 64'd0);
            end else begin
                want = sb.pop_front();
                chk("issue_op",   64'(br_issue_queue_op),        64'(want.op));
                chk("issue_pc",   64'(br_issue_queue_pc),        64'(want.pc));
                chk("issue_imm",  64'(br_issue_queue_imm),       64'(want.imm));
                chk("issue_rs1",  64'(br_issue_queue_rs1_value), 64'(want.v1));
                chk("issue_rs2",  64'(br_issue_queue_rs2_value), 64'(want.v2));
                chk("issue_pdst", 64'(br_issue_queue_Pdst_out),  64'(want.pdst));
            end
        end
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_disp('0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        disp_valid = 1'b0;
        cdb(1'b0, '0, '0);

        #3;
        chk("rst_ready", 64'(disp_ready),        64'd1);
        chk("rst_count", 64'(iq_count),          64'd0);
        chk("rst_en",    64'(br_issue_en),       64'd0);
        chk("rst_pc",    64'(br_issue_queue_pc), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Both sources ready at dispatch: issue two cycles after the dispatch edge.
        set_disp(`BR_OP_BEQ, 'h100, 'h20, 4'd1, 1'b1, 4'd0, 'd5, 1'b1, 4'd0, 'd5);
        push(`BR_OP_BEQ, 'h100, 'h20, 'd5, 'd5, 4'd1);
        tick();
        disp_valid = 1'b0;
        chk("t28_count_n1", 64'(iq_count),    64'd1);
        chk("t28_en_n1",    64'(br_issue_en), 64'd0);
        tick();
        chk("t28_en_n2",    64'(br_issue_en), 64'd1);
        tick();
        chk("t28_en_after", 64'(br_issue_en), 64'd0);
        chk("t28_count",    64'(iq_count),    64'd0);

        // Older A waits on tag 3; younger B is ready and goes first.
        set_disp(`BR_OP_BNE, 'h200, 'h8, 4'd2, 1'b0, 4'd3, 'd0, 1'b1, 4'd0, 'd2);
        tick();
        set_disp(`BR_OP_BLT, 'h300, 'h10, 4'd3, 1'b1, 4'd0, 'd1, 1'b1, 4'd0, 'd1);
        push(`BR_OP_BLT, 'h300, 'h10, 'd1, 'd1, 4'd3);
        tick();
        disp_valid = 1'b0;
        cdb(1'b1, 4'd3, 'd7);
        push(`BR_OP_BNE, 'h200, 'h8, 'd7, 'd2, 4'd2);
        tick();
        cdb(1'b0, '0, '0);
        chk("t29_b_en", 64'(br_issue_en),       64'd1);
        chk("t29_b_pc", 64'(br_issue_queue_pc), 64'h300);
        tick();
        chk("t29_a_en_k2", 64'(br_issue_en),              64'd1);
        chk("t29_a_rs1",   64'(br_issue_queue_rs1_value), 64'd7);
        tick();
        chk("t29_idle", 64'(br_issue_en), 64'd0);
        chk("t29_count", 64'(iq_count),   64'd0);

        // Fill the queue with waiting entries, then a fifth is dropped.
        for (int i = 0; i < 4; i++) begin
            set_disp(`BR_OP_BGE, PC_W'('h400 + 4 * i), WORD_W'(i), TAG_W'(4 + i),
                     1'b0, TAG_W'(10 + i), '0, 1'b1, '0, WORD_W'('h30 + i));
            tick();
        end
        disp_valid = 1'b0;
        chk("t30_full_count", 64'(iq_count),   64'd4);
        chk("t30_full_ready", 64'(disp_ready), 64'd0);
        set_disp(`BR_OP_BGE, 'h4f0, 'h9, 4'd15, 1'b0, 4'd14, '0, 1'b1, '0, 'h3f);
        tick();
        disp_valid = 1'b0;
        chk("t30_5th_dropped", 64'(iq_count), 64'd4);
        cdb(1'b1, 4'd12, 'h55);
        push(`BR_OP_BGE, 'h408, 'd2, 'h55, 'h32, 4'd6);
        tick();
        cdb(1'b0, '0, '0);
        chk("t30_wait_en",    64'(br_issue_en), 64'd0);
        chk("t30_wait_ready", 64'(disp_ready),  64'd0);
        tick();
        chk("t30_slot2_en",    64'(br_issue_en),       64'd1);
        chk("t30_slot2_pc",    64'(br_issue_queue_pc), 64'h408);
        chk("t30_count3",      64'(iq_count),          64'd3);
        chk("t30_ready_again", 64'(disp_ready),        64'd1);
        cdb(1'b1, 4'd13, 'h66);
        push(`BR_OP_BGE, 'h40c, 'd3, 'h66, 'h33, 4'd7);
        tick();
        cdb(1'b0, '0, '0);
        tick();
        chk("t30_shifted_en", 64'(br_issue_en),       64'd1);
        chk("t30_shifted_pc", 64'(br_issue_queue_pc), 64'h40c);
        cdb(1'b1, 4'd10, 'ha0);
        push(`BR_OP_BGE, 'h400, 'd0, 'ha0, 'h30, 4'd4);
        tick();
        cdb(1'b1, 4'd11, 'hb0);
        push(`BR_OP_BGE, 'h404, 'd1, 'hb0, 'h31, 4'd5);
        tick();
        cdb(1'b0, '0, '0);
        tick();
        chk("t30_last_pc", 64'(br_issue_queue_pc), 64'h404);
        tick();
        chk("t30_drained", 64'(iq_count), 64'd0);

        // Same-cycle CDB capture on enqueue.
        set_disp(`BR_OP_BLTU, 'h500, 'h40, 4'd8, 1'b1, 4'd0, 'h1, 1'b0, 4'd9, '0);
        cdb(1'b1, 4'd9, 'hDEAD);
        push(`BR_OP_BLTU, 'h500, 'h40, 'h1, 'hDEAD, 4'd8);
        tick();
        disp_valid = 1'b0;
        cdb(1'b0, '0, '0);
        chk("t31_count", 64'(iq_count), 64'd1);
        tick();
        chk("t31_en",  64'(br_issue_en),              64'd1);
        chk("t31_rs2", 64'(br_issue_queue_rs2_value), 64'hDEAD);
        tick();

        // A broadcast on an already-ready source's tag must not disturb it.
        set_disp(`BR_OP_BGEU, 'h600, 'h50, 4'd9, 1'b1, 4'd4, 'h11, 1'b0, 4'd6, '0);
        tick();
        disp_valid = 1'b0;
        cdb(1'b1, 4'd4, 'h99);
        tick();
        cdb(1'b1, 4'd6, 'h22);
        push(`BR_OP_BGEU, 'h600, 'h50, 'h11, 'h22, 4'd9);
        tick();
        cdb(1'b0, '0, '0);
        chk("t22_no_early", 64'(br_issue_en), 64'd0);
        tick();
        chk("t22_en",  64'(br_issue_en),              64'd1);
        chk("t22_rs1", 64'(br_issue_queue_rs1_value), 64'h11);
        tick();

        // Flush with a concurrent dispatch wins over everything.
        set_disp(`BR_OP_BEQ, 'h700, '0, 4'd10, 1'b0, 4'd7, '0, 1'b1, '0, '0);
        tick();
        set_disp(`BR_OP_BEQ, 'h704, '0, 4'd11, 1'b0, 4'd8, '0, 1'b1, '0, '0);
        tick();
        set_disp(`BR_OP_BEQ, 'h708, '0, 4'd12, 1'b1, '0, '0, 1'b1, '0, '0);
        tick();
        chk("t32_pre_count", 64'(iq_count), 64'd3);
        flush = 1'b1;
        set_disp(`BR_OP_BEQ, 'h70c, '0, 4'd13, 1'b1, '0, '0, 1'b1, '0, '0);
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        chk("t32_count", 64'(iq_count),    64'd0);
        chk("t32_en",    64'(br_issue_en), 64'd0);
        cdb(1'b1, 4'd7, 'h1);
        tick();
        cdb(1'b1, 4'd8, 'h2);
        tick();
        cdb(1'b0, '0, '0);
        tick();
        tick();
        chk("t32_still_empty", 64'(iq_count),    64'd0);
        chk("t32_no_issue",    64'(br_issue_en), 64'd0);

        // Asynchronous reset while two ready entries sit in the queue.
        set_disp(`BR_OP_BNE, 'h800, '0, 4'd11, 1'b0, 4'd5, '0, 1'b1, '0, '0);
        tick();
        set_disp(`BR_OP_BNE, 'h804, '0, 4'd12, 1'b0, 4'd5, '0, 1'b1, '0, '0);
        tick();
        disp_valid = 1'b0;
        cdb(1'b1, 4'd5, 'h77);
        tick();
        cdb(1'b0, '0, '0);
        chk("t33_pre_count", 64'(iq_count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t33_en",    64'(br_issue_en),              64'd0);
        chk("t33_count", 64'(iq_count),                 64'd0);
        chk("t33_ready", 64'(disp_ready),               64'd1);
        chk("t33_pc",    64'(br_issue_queue_pc),        64'd0);
        chk("t33_rs1",   64'(br_issue_queue_rs1_value), 64'd0);
        chk("t33_pdst",  64'(br_issue_queue_Pdst_out),  64'd0);
        tick();
        chk("t33_ready_in_rst", 64'(disp_ready), 64'd1);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("t33_no_stale_count", 64'(iq_count),    64'd0);
        chk("t33_no_stale_en",    64'(br_issue_en), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
